muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

- Sequencing controller for the CPU's HI/LO arithmetic unit.
- Accepts MULT/DIV requests from the control unit and owns the architectural HI and LO registers.
- MULT: drives the shared registered Booth multiplier (instantiated beside this block) and writes its 64-bit product into HI/LO.
- DIV: runs an internal 32-iteration signed restoring division, with LO = quotient and HI = remainder.

## Interface

Parameters:
- WIDTH, 32, operand width; only 32 is supported.
- DIV_ITERS, 32, division iterations; must equal WIDTH.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset, sampled on posedge clock.
- start  input  1  request strobe; sampled only when busy=0.
- op  input  1  0 = MULT, 1 = DIV (signed); sampled with start.
- a  input  32  multiplicand / dividend; sampled with start.
- b  input  32  multiplier / divisor; sampled with start.
- mult_a  output  32  operand A to the multiplier; holds the captured a.
- mult_b  output  32  operand B to the multiplier; holds the captured b.
- mult_hi  input  32  multiplier product[63:32].
- mult_low  input  32  multiplier product[31:0].
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.
- div_zero  output  1  one-cycle pulse coincident with done when divisor = 0.
- hi  output  32  architectural HI register.
- lo  output  32  architectural LO register.

## Operation

States: IDLE, M_WAIT, M_WRITE, D_PREP, D_ITER, D_FIX, DONE.

- **Reset** (reset=0 at a posedge): go to IDLE. hi, lo, mult_a, mult_b, the iteration counter and all internal registers clear to 0. busy=0, done=0, div_zero=0. This applies from any state; an aborted operation writes nothing.
- **IDLE or DONE**, start=1:
  - Capture a and b into operand registers; mult_a/mult_b follow them.
  - op=0 → M_WAIT; op=1 → D_PREP.
  - start=0 → IDLE.
- **M_WAIT**: the multiplier registers its product at the end of this cycle. → M_WRITE.
- **M_WRITE**: hi←mult_hi, lo←mult_low. → DONE.
- **D_PREP**:
  - If the divisor is 0: hi/lo unchanged, set the div_zero flag, → DONE.
  - Otherwise:
    - Load dividend magnitude |a| into the quotient shift register.
    - Load divisor magnitude |b| into the divisor register.
    - Clear the 33-bit partial remainder.
    - Latch q_neg = a[31]^b[31] and r_neg = a[31].
    - Clear the counter. → D_ITER.
- **D_ITER**, one iteration per cycle:
  - Shift {rem, quot} left by 1.
  - trial = rem − divisor.
  - If trial ≥ 0: rem←trial and quot[0]←1; otherwise quot[0]←0.
  - counter+1. After the 32nd iteration → D_FIX.
- **D_FIX**: lo←q_neg ? −quot : quot; hi←r_neg ? −rem : rem. → DONE.
- **DONE**: done=1 (and div_zero=1 if flagged) for exactly this cycle; busy=0. Follows the IDLE transition rules, so back-to-back requests are allowed.
- **Arithmetic rules**:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Magnitudes are computed in 33 bits, so |−2^31| is exact.
  - −2^31 / −1 gives lo=0x80000000, hi=0 with no flag.
  - MULT result is the full signed 64-bit product.
- **Start handling**: start while busy=1 is ignored and never queued. a/b changes while busy have no effect.

## Timing

Cycle 0 is the cycle in which start=1 is sampled with busy=0.

- **busy**: high from cycle 1 until the cycle before DONE; low in IDLE and DONE.
- **MULT**:
  - M_WAIT in cycle 1, M_WRITE in cycle 2.
  - hi/lo show the new values and done=1 in cycle 3.
  - Latency: 3 cycles.
- **DIV**:
  - D_PREP in cycle 1, D_ITER in cycles 2–33, D_FIX in cycle 34.
  - hi/lo show the new values and done=1 in cycle 35.
  - Latency: 35 cycles.
- **DIV by zero**: done=1 and div_zero=1 in cycle 2; hi/lo keep their prior values.
- **hi/lo**: change only on the M_WRITE or D_FIX edge, or on reset.
- **mult_a/mult_b**: stable from cycle 1 until the next accepted start.
- **Reset** sampled at the edge ending cycle k: outputs read their reset values in cycle k+1.

## Test plan

- **Reset**: hold reset=0 for 2 cycles → hi=lo=0, busy=done=div_zero=0, mult_a=mult_b=0.
- **MULT, small signed**: a=7, b=0xFFFFFFFD (−3), op=0 → done in cycle 3; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high in cycles 1–2 only.
- **MULT, extreme operands**: a=b=0x80000000 → hi=0x40000000, lo=0. Then issue start with a=0xFFFFFFFF, b=0xFFFFFFFF in the done cycle → accepted; hi=0, lo=1 three cycles later.
- **DIV, signed**:
  - a=100, b=0xFFFFFFF9 (−7) → done in cycle 35; lo=0xFFFFFFF2, hi=2.
  - a=0xFFFFFF9C (−100), b=7 → lo=0xFFFFFFF2, hi=0xFFFFFFFE.
  - a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- **DIV by zero**: preload hi=0x12, lo=0x34 via a MULT; then a=5, b=0, op=1 → done=div_zero=1 in cycle 2; hi=0x12, lo=0x34.
- **Abuse**:
  - Pulse start with new operands in cycles 5 and 20 of a DIV → ignored; result matches the original operands.
  - Assert reset=0 in cycle 10 of a DIV → IDLE next cycle, hi=lo=0, no done pulse.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer: MULT via the external registered multiplier,
// signed DIV via an internal restoring divider.
module muldiv_ctrl #(
    parameter int WIDTH     = 32,
    parameter int DIV_ITERS = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] mult_a,
    output logic [WIDTH-1:0] mult_b,
    input  logic [WIDTH-1:0] mult_hi,
    input  logic [WIDTH-1:0] mult_low,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(DIV_ITERS);

    typedef enum logic [2:0] {
        IDLE,
        M_WAIT,
        M_WRITE,
        D_PREP,
        D_ITER,
        D_FIX,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH:0]   dvsr_q, dvsr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH:0]   b_mag;
    logic [WIDTH+1:0] rem_sh;
    logic [WIDTH+1:0] trial;

    // An unsigned 32-bit magnitude already holds |-2^31| exactly.
    assign a_mag  = a_q[WIDTH-1] ? -a_q : a_q;
    assign b_mag  = b_q[WIDTH-1] ? -{1'b1, b_q} : {1'b0, b_q};
    assign rem_sh = {rem_q, quot_q[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, dvsr_q};

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            dvsr_q  <= '0;
            cnt_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            dvsr_q  <= dvsr_d;
            cnt_q   <= cnt_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        dvsr_d  = dvsr_q;
        cnt_d   = cnt_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        dz_d    = dz_q;

        unique case (state_q)
            IDLE, DONE: begin
                dz_d = 1'b0;
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = op ? D_PREP : M_WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            M_WAIT: begin
                state_d = M_WRITE;
            end
            M_WRITE: begin
                hi_d    = mult_hi;
                lo_d    = mult_low;
                state_d = DONE;
            end
            D_PREP: begin
                if (b_q == '0) begin
                    dz_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    quot_d  = a_mag;
                    dvsr_d  = b_mag;
                    rem_d   = '0;
                    q_neg_d = a_q[WIDTH-1] ^ b_q[WIDTH-1];
                    r_neg_d = a_q[WIDTH-1];
                    cnt_d   = '0;
                    state_d = D_ITER;
                end
            end
            D_ITER: begin
                if (!trial[WIDTH+1]) begin
                    rem_d  = trial[WIDTH:0];
                    quot_d = {quot_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d  = rem_sh[WIDTH:0];
                    quot_d = {quot_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DIV_ITERS - 1)) begin
                    state_d = D_FIX;
                end
            end
            D_FIX: begin
                lo_d    = q_neg_q ? -quot_q : quot_q;
                hi_d    = r_neg_q ? -rem_q[WIDTH-1:0]
                                  : rem_q[WIDTH-1:0];
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mult_a   = a_q;
    assign mult_b   = b_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = (state_q != IDLE) && (state_q != DONE);
    assign done     = (state_q == DONE);
    assign div_zero = (state_q == DONE) && dz_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized bench for muldiv_ctrl against a plain-arithmetic
// HI/LO model, with a behavioural registered multiplier beside it.
module tb_muldiv_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        op    = 1'b0;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic [31:0] mult_a, mult_b;
    logic [31:0] mult_hi, mult_low;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    muldiv_ctrl #(.WIDTH(32), .DIV_ITERS(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .a(a), .b(b), .mult_a(mult_a), .mult_b(mult_b),
        .mult_hi(mult_hi), .mult_low(mult_low),
        .busy(busy), .done(done), .div_zero(div_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;

    // One-cycle registered signed multiplier
    always @(posedge clock) begin
        {mult_hi, mult_low} <= $signed({{32{mult_a[31]}}, mult_a})
                             * $signed({{32{mult_b[31]}}, mult_b});
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic o, input logic [31:0] x,
                                  input logic [31:0] y,
                                  input logic [31:0] oh,
                                  input logic [31:0] ol,
                                  output logic [31:0] nh,
                                  output logic [31:0] nl,
                                  output logic dz, output int lat);
        longint sx, sy, p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        dz = 1'b0;
        nh = oh;
        nl = ol;
        if (!o) begin
            p   = sx * sy;
            nh  = p[63:32];
            nl  = p[31:0];
            lat = 3;
        end else if (y == 32'd0) begin
            dz  = 1'b1;
            lat = 2;
        end else begin
            nl  = 32'(sx / sy);
            nh  = 32'(sx % sy);
            lat = 35;
        end
    endfunction

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic run(input string tag, input logic o,
                       input logic [31:0] x, input logic [31:0] y,
                       input int abuse = 0, input int rst_at = 0);
        logic [31:0] nh, nl;
        logic        dz;
        int          lat, cyc, seen;
        model(o, x, y, m_hi, m_lo, nh, nl, dz, lat);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clock);
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < 60) begin
            chk({tag, ".busy"}, 64'(busy), 64'd1);
            chk({tag, ".ma"}, 64'(mult_a), 64'(x));
            chk({tag, ".mb"}, 64'(mult_b), 64'(y));
            chk({tag, ".hold"}, {hi, lo}, {m_hi, m_lo});
            if (rst_at == cyc) begin
                reset = 1'b0;
                @(negedge clock);
                reset = 1'b1;
                m_hi  = '0;
                m_lo  = '0;
                chk({tag, ".rst_st"}, {61'd0, busy, done, div_zero}, 64'd0);
                chk({tag, ".rst_hl"}, {hi, lo}, 64'd0);
                chk({tag, ".rst_m"}, {mult_a, mult_b}, 64'd0);
                seen = 0;
                for (int i = 0; i < 40; i++) begin
                    if (done || busy) seen++;
                    @(negedge clock);
                end
                chk({tag, ".no_done"}, 64'(seen), 64'd0);
                return;
            end
            start = (abuse != 0) && (cyc == 5 || cyc == 20);
            a     = $urandom;
            b     = $urandom;
            op    = 1'($urandom);
            @(negedge clock);
            cyc++;
        end
        start = 1'b0;
        chk({tag, ".lat"}, 64'(cyc), 64'(lat));
        chk({tag, ".done"}, {62'd0, done, busy}, 64'd2);
        chk({tag, ".dz"}, 64'(div_zero), 64'(dz));
        chk({tag, ".hi"}, 64'(hi), 64'(nh));
        chk({tag, ".lo"}, 64'(lo), 64'(nl));
        m_hi = nh;
        m_lo = nl;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'd0;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset.st", {61'd0, busy, done, div_zero}, 64'd0);
        chk("reset.hl", {hi, lo}, 64'd0);
        chk("reset.m", {mult_a, mult_b}, 64'd0);
        reset = 1'b1;
        @(negedge clock);

        run("mul_small", 1'b0, 32'd7, 32'hFFFF_FFFD);
        chk("mul_small.k", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        repeat (2) @(negedge clock);
        run("mul_ext", 1'b0, 32'h8000_0000, 32'h8000_0000);
        chk("mul_ext.k", {hi, lo}, 64'h4000_0000_0000_0000);
        run("mul_b2b", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("mul_b2b.k", {hi, lo}, 64'h0000_0000_0000_0001);

        run("div_a", 1'b1, 32'd100, 32'hFFFF_FFF9);
        chk("div_a.k", {hi, lo}, 64'h0000_0002_FFFF_FFF2);
        run("div_b", 1'b1, 32'hFFFF_FF9C, 32'd7);
        chk("div_b.k", {hi, lo}, 64'hFFFF_FFFE_FFFF_FFF2);
        run("div_c", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_c.k", {hi, lo}, 64'h0000_0000_8000_0000);

        run("pre", 1'b0, 32'h0001_2345, 32'h0006_7890);
        run("div0", 1'b1, 32'd5, 32'd0);

        run("abuse", 1'b1, 32'd123457, 32'hFFFF_FF85, 1);
        run("abort", 1'b1, 32'd999, 32'd10, 0, 10);
        run("post", 1'b1, 32'd999, 32'd10);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clock);
            run("rnd", 1'($urandom), pick(), pick(),
                int'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
